// File: rtl/obi_fill_master.sv
//==============================================================================
// Module   : obi_fill_master
// Brief    : Register-programmed OBI initiator; fills a region with a pattern
//            or reads it back and accumulates a 32-bit sum.
// Revision : 1.0
//==============================================================================
`default_nettype none

package obi_fill_pkg;

  typedef struct packed {
    logic        valid;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } reg_req_t;

  typedef struct packed {
    logic        ready;
    logic [31:0] rdata;
    logic        error;
  } reg_rsp_t;

  typedef struct packed {
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } obi_req_t;

  typedef struct packed {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
  } obi_resp_t;

endpackage

module obi_fill_master
  import obi_fill_pkg::*;
#(
  parameter int unsigned MAX_LEN_W = 16
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  reg_req_t  reg_req_i,
  output reg_rsp_t  reg_rsp_o,
  output obi_req_t  obi_req_o,
  input  obi_resp_t obi_rsp_i,
  output logic      done_int_o
);

  localparam logic [4:0] c_off_addr    = 5'h00;
  localparam logic [4:0] c_off_len     = 5'h04;
  localparam logic [4:0] c_off_pattern = 5'h08;
  localparam logic [4:0] c_off_ctrl    = 5'h0C;
  localparam logic [4:0] c_off_status  = 5'h10;
  localparam logic [4:0] c_off_sum     = 5'h14;
  localparam logic [4:0] c_off_count   = 5'h18;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ    = 2'd1,
    S_WAIT_R = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // Software-visible configuration
  logic [31:0]          r_addr_cfg;
  logic [MAX_LEN_W-1:0] r_len_cfg;
  logic [31:0]          r_pattern_cfg;
  logic                 r_mode_cfg;
  logic                 r_incr_cfg;

  // Job state
  state_t               r_state;
  logic [31:0]          r_cur_addr;
  logic [31:0]          r_fill;
  logic [31:0]          r_sum;
  logic [MAX_LEN_W-1:0] r_len_job;
  logic [MAX_LEN_W-1:0] r_count;
  logic                 r_mode;
  logic                 r_incr;
  logic                 r_abort_pend;
  logic                 r_done;
  logic                 r_aborted;
  logic                 r_done_int;
  logic                 r_req;
  logic                 r_we;
  logic [3:0]           r_be;

  logic [4:0]           w_off;
  logic                 w_wr;
  logic                 w_busy;
  logic                 w_in_xfer;
  logic                 w_bad_off;
  logic                 w_ctrl_wr;
  logic                 w_cfg_wr;
  logic                 w_start;
  logic                 w_abort;
  logic                 w_mode_new;
  logic                 w_incr_new;
  logic                 w_last;
  logic [MAX_LEN_W-1:0] w_count_inc;
  logic [31:0]          w_rdata;
  logic                 w_unused_ok;

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  assign w_off       = reg_req_i.addr[4:0];
  assign w_wr        = reg_req_i.valid & reg_req_i.write;
  assign w_busy      = (r_state != S_IDLE);
  assign w_in_xfer   = (r_state == S_REQ) | (r_state == S_WAIT_R);
  assign w_cfg_wr    = w_wr & ~w_busy;
  assign w_ctrl_wr   = w_wr & (w_off == c_off_ctrl) & reg_req_i.wstrb[0];
  assign w_start     = w_ctrl_wr & reg_req_i.wdata[0] & ~w_busy;
  assign w_abort     = w_ctrl_wr & reg_req_i.wdata[3] & w_in_xfer;
  assign w_mode_new  = (w_ctrl_wr & ~w_busy) ? reg_req_i.wdata[1] : r_mode_cfg;
  assign w_incr_new  = (w_ctrl_wr & ~w_busy) ? reg_req_i.wdata[2] : r_incr_cfg;
  assign w_count_inc = r_count + {{(MAX_LEN_W-1){1'b0}}, 1'b1};
  // An abort written in the same cycle as rvalid still stops after this word
  assign w_last      = (w_count_inc == r_len_job) | r_abort_pend | w_abort;
  assign w_unused_ok = ^reg_req_i.addr[31:5];

  always_comb begin
    w_rdata   = 32'h0;
    w_bad_off = 1'b0;
    case (w_off)
      c_off_addr:    w_rdata = r_addr_cfg;
      c_off_len:     w_rdata = 32'(r_len_cfg);
      c_off_pattern: w_rdata = r_pattern_cfg;
      c_off_ctrl:    w_rdata = 32'h0;
      c_off_status:  w_rdata = {29'h0, r_aborted, r_done, w_busy};
      c_off_sum:     w_rdata = r_sum;
      c_off_count:   w_rdata = 32'(r_count);
      default:       w_bad_off = 1'b1;
    endcase
  end

  assign reg_rsp_o = '{
    ready: reg_req_i.valid,
    rdata: reg_req_i.valid ? w_rdata : 32'h0,
    error: reg_req_i.valid & w_bad_off
  };

  assign obi_req_o = '{
    req:   r_req,
    we:    r_we,
    be:    r_be,
    addr:  r_cur_addr,
    wdata: r_fill
  };

  assign done_int_o = r_done_int;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_addr_cfg    <= 32'h0;
      r_len_cfg     <= '0;
      r_pattern_cfg <= 32'h0;
      r_mode_cfg    <= 1'b0;
      r_incr_cfg    <= 1'b0;
    end else if (w_cfg_wr) begin
      if (w_off == c_off_addr) begin
        r_addr_cfg <= f_merge(r_addr_cfg, reg_req_i.wdata, reg_req_i.wstrb) & 32'hFFFF_FFFC;
      end
      if (w_off == c_off_len) begin
        r_len_cfg <= MAX_LEN_W'(f_merge(32'(r_len_cfg), reg_req_i.wdata, reg_req_i.wstrb));
      end
      if (w_off == c_off_pattern) begin
        r_pattern_cfg <= f_merge(r_pattern_cfg, reg_req_i.wdata, reg_req_i.wstrb);
      end
      r_mode_cfg <= w_mode_new;
      r_incr_cfg <= w_incr_new;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= 32'h0;
      r_fill       <= 32'h0;
      r_sum        <= 32'h0;
      r_len_job    <= '0;
      r_count      <= '0;
      r_mode       <= 1'b0;
      r_incr       <= 1'b0;
      r_abort_pend <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_done_int   <= 1'b0;
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_be         <= 4'h0;
    end else begin
      r_done_int <= 1'b0;
      if (w_abort) begin
        r_abort_pend <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cur_addr <= r_addr_cfg;
            r_fill     <= r_pattern_cfg;
            r_len_job  <= r_len_cfg;
            r_mode     <= w_mode_new;
            r_incr     <= w_incr_new;
            r_we       <= ~w_mode_new;
            r_count    <= '0;
            r_done     <= 1'b0;
            r_aborted  <= 1'b0;
            if (w_mode_new) begin
              r_sum <= 32'h0;
            end
            if (r_len_cfg != '0) begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_be    <= 4'hF;
            end else begin
              r_state    <= S_DONE;
              r_done_int <= 1'b1;
            end
          end
        end

        // Request fields are held by their registers until the grant
        S_REQ: begin
          if (obi_rsp_i.gnt) begin
            r_req   <= 1'b0;
            r_be    <= 4'h0;
            r_state <= S_WAIT_R;
          end
        end

        S_WAIT_R: begin
          if (obi_rsp_i.rvalid) begin
            r_count    <= w_count_inc;
            r_cur_addr <= r_cur_addr + 32'd4;
            if (r_mode) begin
              r_sum <= r_sum + obi_rsp_i.rdata;
            end
            if (r_incr) begin
              r_fill <= r_fill + 32'd1;
            end
            if (w_last) begin
              r_state    <= S_DONE;
              r_done_int <= 1'b1;
            end else begin
              r_state <= S_REQ;
              r_req   <= 1'b1;
              r_be    <= 4'hF;
            end
          end
        end

        S_DONE: begin
          r_done       <= 1'b1;
          r_aborted    <= r_aborted | r_abort_pend;
          r_abort_pend <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_obi_fill_master.sv
//==============================================================================
// Module   : tb_obi_fill_master
// Brief    : Scoreboard bench for obi_fill_master with a delay-programmable slave.
// Revision : 1.0
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_obi_fill_master;
  import obi_fill_pkg::*;

  localparam logic [31:0] c_a_addr    = 32'h00;
  localparam logic [31:0] c_a_len     = 32'h04;
  localparam logic [31:0] c_a_pattern = 32'h08;
  localparam logic [31:0] c_a_ctrl    = 32'h0C;
  localparam logic [31:0] c_a_status  = 32'h10;
  localparam logic [31:0] c_a_sum     = 32'h14;
  localparam logic [31:0] c_a_count   = 32'h18;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  logic      clk = 1'b0;
  logic      rst_n;
  reg_req_t  reg_req;
  reg_rsp_t  reg_rsp;
  obi_req_t  obi_req;
  obi_resp_t obi_rsp;
  logic      done_int;

  txn_t        exp_q[$];
  logic [31:0] rd_q[$];
  int          gnt_dly = 0;
  int          rv_dly  = 0;
  int          n_total;
  int          n_bad;

  always #5 clk = ~clk;

  obi_fill_master #(.MAX_LEN_W(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .reg_req_i  (reg_req),
    .reg_rsp_o  (reg_rsp),
    .obi_req_o  (obi_req),
    .obi_rsp_i  (obi_rsp),
    .done_int_o (done_int)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required finish before limit");
    $fatal(1);
  end

  // Slave: grants after gnt_dly cycles, responds rv_dly cycles after the grant
  task automatic slave_loop();
    txn_t        e;
    logic [31:0] a;
    logic [31:0] d;
    logic        w;
    obi_rsp = '0;
    forever begin
      @(negedge clk);
      obi_rsp.gnt    = 1'b0;
      obi_rsp.rvalid = 1'b0;
      if (rst_n === 1'b1 && obi_req.req === 1'b1) begin
        a = obi_req.addr;
        w = obi_req.we;
        d = obi_req.wdata;
        for (int k = 0; k < gnt_dly; k++) begin
          @(negedge clk);
          n_total++;
          if (obi_req.req !== 1'b1 || obi_req.addr !== a || obi_req.we !== w || obi_req.wdata !== d) begin
            n_bad++;
            $display("FAIL req_stable: req=%b addr=%h we=%b wdata=%h, required req=1 addr=%h we=%b wdata=%h",
                     obi_req.req, obi_req.addr, obi_req.we, obi_req.wdata, a, w, d);
          end
        end
        obi_rsp.gnt = 1'b1;
        n_total++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_req: addr=%h we=%b, required no request", obi_req.addr, obi_req.we);
        end else begin
          e = exp_q.pop_front();
          if (obi_req.addr !== e.addr || obi_req.we !== e.we || obi_req.be !== 4'hF ||
              (e.we && obi_req.wdata !== e.wdata)) begin
            n_bad++;
            $display("FAIL obi_txn: addr=%h we=%b be=%h wdata=%h, required addr=%h we=%b be=f wdata=%h",
                     obi_req.addr, obi_req.we, obi_req.be, obi_req.wdata, e.addr, e.we, e.wdata);
          end
        end
        @(negedge clk);
        obi_rsp.gnt = 1'b0;
        for (int k = 0; k < rv_dly; k++) begin
          n_total++;
          if (obi_req.req !== 1'b0) begin
            n_bad++;
            $display("FAIL outstanding: req=%b while awaiting rvalid, required 0", obi_req.req);
          end
          @(negedge clk);
        end
        n_total++;
        if (obi_req.req !== 1'b0) begin
          n_bad++;
          $display("FAIL outstanding: req=%b at rvalid, required 0", obi_req.req);
        end
        obi_rsp.rvalid = 1'b1;
        if (rd_q.size() != 0) obi_rsp.rdata = rd_q.pop_front();
        else obi_rsp.rdata = 32'h0;
      end
    end
  endtask

  task automatic reg_write(input logic [31:0] a, input logic [31:0] d);
    reg_req.valid = 1'b1;
    reg_req.write = 1'b1;
    reg_req.addr  = a;
    reg_req.wdata = d;
    reg_req.wstrb = 4'hF;
    @(negedge clk);
    reg_req.valid = 1'b0;
    reg_req.write = 1'b0;
  endtask

  task automatic reg_read(input logic [31:0] a, output logic [31:0] d, output logic err);
    reg_req.valid = 1'b1;
    reg_req.write = 1'b0;
    reg_req.addr  = a;
    reg_req.wdata = 32'h0;
    reg_req.wstrb = 4'hF;
    #1;
    d   = reg_rsp.rdata;
    err = reg_rsp.error;
    @(negedge clk);
    reg_req.valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] base, input int n, input logic [31:0] pat,
                          input logic incr, input logic we);
    txn_t e;
    for (int i = 0; i < n; i++) begin
      e.addr  = base + 32'(4 * i);
      e.we    = we;
      e.wdata = incr ? pat + 32'(i) : pat;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = -1;
    for (int i = 0; i < limit; i++) begin
      if (done_int === 1'b1) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    logic        err;
    n_total++;
    if (obi_req !== '0 || done_int !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: obi_req=%h done=%b, required 0 0", obi_req, done_int);
    end
    n_total++;
    if (reg_rsp.rdata !== 32'h0 || reg_rsp.error !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_rsp: rdata=%h error=%b, required 0 0", reg_rsp.rdata, reg_rsp.error);
    end
    reg_read(c_a_status, v, err);
    n_total++;
    if (v !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_status: got %h, required 0", v);
    end
  endtask

  task automatic test_fill();
    int          cyc;
    logic [31:0] v;
    logic        err;
    gnt_dly = 0;
    rv_dly  = 0;
    reg_write(c_a_addr, 32'h100);
    reg_write(c_a_len, 32'd4);
    reg_write(c_a_pattern, 32'hA0);
    push_exp(32'h100, 4, 32'hA0, 1'b1, 1'b1);
    reg_write(c_a_ctrl, 32'h5);
    n_total++;
    if (obi_req.req !== 1'b1) begin
      n_bad++;
      $display("FAIL fill_req_start: req=%b one cycle after START, required 1", obi_req.req);
    end
    wait_done(100, cyc);
    n_total++;
    if (cyc < 0) begin
      n_bad++;
      $display("FAIL fill_done: no done pulse, required one");
    end
    @(negedge clk);
    n_total++;
    if (done_int !== 1'b0) begin
      n_bad++;
      $display("FAIL fill_pulse: done=%b after pulse, required 0", done_int);
    end
    reg_read(c_a_count, v, err);
    n_total++;
    if (v !== 32'd4) begin
      n_bad++;
      $display("FAIL fill_count: got %0d, required 4", v);
    end
    reg_read(c_a_status, v, err);
    n_total++;
    if (v !== 32'h2) begin
      n_bad++;
      $display("FAIL fill_status: got %h, required 2", v);
    end
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL fill_pending: %0d expected requests left, required 0", exp_q.size());
    end
  endtask

  task automatic test_read_sum();
    int          cyc;
    logic [31:0] v;
    logic        err;
    reg_write(c_a_addr, 32'h200);
    reg_write(c_a_len, 32'd3);
    rd_q.push_back(32'hFFFF_FFFF);
    rd_q.push_back(32'h2);
    rd_q.push_back(32'h5);
    push_exp(32'h200, 3, 32'h0, 1'b0, 1'b0);
    reg_write(c_a_ctrl, 32'h3);
    wait_done(100, cyc);
    n_total++;
    if (cyc < 0) begin
      n_bad++;
      $display("FAIL read_done: no done pulse, required one");
    end
    @(negedge clk);
    reg_read(c_a_sum, v, err);
    n_total++;
    if (v !== 32'h6) begin
      n_bad++;
      $display("FAIL read_sum: got %h, required 00000006", v);
    end
    reg_read(c_a_count, v, err);
    n_total++;
    if (v !== 32'd3) begin
      n_bad++;
      $display("FAIL read_count: got %0d, required 3", v);
    end
  endtask

  task automatic test_backpressure();
    int          cyc;
    logic [31:0] v;
    logic [31:0] c1;
    logic        err;
    gnt_dly = 3;
    rv_dly  = 2;
    reg_write(c_a_addr, 32'h300);
    reg_write(c_a_len, 32'd4);
    reg_write(c_a_pattern, 32'h55);
    push_exp(32'h300, 4, 32'h55, 1'b0, 1'b1);
    reg_write(c_a_ctrl, 32'h1);
    reg_read(c_a_status, v, err);
    n_total++;
    if (v[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL bp_busy: status=%h, required busy bit 1", v);
    end
    c1 = 32'h0;
    for (int i = 0; i < 50 && c1 == 32'h0; i++) reg_read(c_a_count, c1, err);
    reg_write(c_a_addr, 32'h900);
    reg_write(c_a_ctrl, 32'h5);
    reg_read(c_a_count, v, err);
    n_total++;
    if (c1 == 32'h0 || v < c1) begin
      n_bad++;
      $display("FAIL start_busy_count: count=%0d after START (was %0d), required >= %0d and nonzero", v, c1, c1);
    end
    wait_done(200, cyc);
    n_total++;
    if (cyc < 0) begin
      n_bad++;
      $display("FAIL bp_done: no done pulse, required one");
    end
    @(negedge clk);
    reg_read(c_a_count, v, err);
    n_total++;
    if (v !== 32'd4) begin
      n_bad++;
      $display("FAIL bp_count: got %0d, required 4", v);
    end
    reg_read(c_a_addr, v, err);
    n_total++;
    if (v !== 32'h300) begin
      n_bad++;
      $display("FAIL busy_addr_write: ADDR=%h, required 00000300", v);
    end
  endtask

  task automatic test_abort();
    int          cyc;
    logic [31:0] v;
    logic        err;
    logic        req_seen;
    gnt_dly = 4;
    rv_dly  = 1;
    reg_write(c_a_addr, 32'h400);
    reg_write(c_a_len, 32'd8);
    reg_write(c_a_pattern, 32'h10);
    push_exp(32'h400, 2, 32'h10, 1'b1, 1'b1);
    reg_write(c_a_ctrl, 32'h5);
    v = 32'h0;
    for (int i = 0; i < 50 && v == 32'h0; i++) reg_read(c_a_count, v, err);
    reg_write(c_a_ctrl, 32'h8);
    wait_done(200, cyc);
    n_total++;
    if (cyc < 0) begin
      n_bad++;
      $display("FAIL abort_done: no done pulse, required one");
    end
    req_seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (obi_req.req === 1'b1) req_seen = 1'b1;
    end
    n_total++;
    if (req_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_no_req: req seen after abort, required none");
    end
    reg_read(c_a_status, v, err);
    n_total++;
    if (v !== 32'h6) begin
      n_bad++;
      $display("FAIL abort_status: got %h, required 6", v);
    end
    reg_read(c_a_count, v, err);
    n_total++;
    if (v !== 32'd2) begin
      n_bad++;
      $display("FAIL abort_count: got %0d, required 2", v);
    end
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL abort_pending: %0d expected requests left, required 0", exp_q.size());
    end
  endtask

  task automatic test_len0();
    logic [31:0] v;
    logic        err;
    gnt_dly = 0;
    rv_dly  = 0;
    reg_write(c_a_len, 32'd0);
    reg_req.valid = 1'b1;
    reg_req.write = 1'b1;
    reg_req.addr  = c_a_ctrl;
    reg_req.wdata = 32'h1;
    reg_req.wstrb = 4'hF;
    @(negedge clk);
    reg_req.valid = 1'b0;
    reg_req.write = 1'b0;
    n_total++;
    if (done_int !== 1'b1 || obi_req.req !== 1'b0) begin
      n_bad++;
      $display("FAIL len0_n1: done=%b req=%b, required done=1 req=0", done_int, obi_req.req);
    end
    @(negedge clk);
    n_total++;
    if (done_int !== 1'b0) begin
      n_bad++;
      $display("FAIL len0_pulse: done=%b, required 0", done_int);
    end
    reg_read(c_a_status, v, err);
    n_total++;
    if (v !== 32'h2) begin
      n_bad++;
      $display("FAIL len0_status: got %h, required 2", v);
    end
  endtask

  task automatic test_wrap();
    int          cyc;
    logic [31:0] v;
    logic        err;
    reg_write(c_a_addr, 32'hFFFF_FFFC);
    reg_write(c_a_len, 32'd2);
    reg_write(c_a_pattern, 32'h77);
    push_exp(32'hFFFF_FFFC, 2, 32'h77, 1'b0, 1'b1);
    reg_write(c_a_ctrl, 32'h1);
    wait_done(100, cyc);
    n_total++;
    if (cyc < 0) begin
      n_bad++;
      $display("FAIL wrap_done: no done pulse, required one");
    end
    @(negedge clk);
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL wrap_pending: %0d expected requests left, required 0", exp_q.size());
    end
    reg_read(c_a_count, v, err);
    n_total++;
    if (v !== 32'd2) begin
      n_bad++;
      $display("FAIL wrap_count: got %0d, required 2", v);
    end
  endtask

  task automatic test_bad_offset();
    logic [31:0] v;
    logic        err;
    reg_read(32'h1C, v, err);
    n_total++;
    if (err !== 1'b1 || v !== 32'h0) begin
      n_bad++;
      $display("FAIL bad_offset: error=%b rdata=%h, required error=1 rdata=0", err, v);
    end
    reg_read(c_a_ctrl, v, err);
    n_total++;
    if (err !== 1'b0 || v !== 32'h0) begin
      n_bad++;
      $display("FAIL ctrl_read: error=%b rdata=%h, required error=0 rdata=0", err, v);
    end
    reg_read(c_a_pattern, v, err);
    n_total++;
    if (err !== 1'b0 || v !== 32'h77) begin
      n_bad++;
      $display("FAIL pattern_read: error=%b rdata=%h, required error=0 rdata=77", err, v);
    end
  endtask

  task automatic test_reset_midjob();
    int          cyc;
    logic [31:0] v;
    logic        err;
    logic        bad_seen;
    gnt_dly = 0;
    rv_dly  = 5;
    reg_write(c_a_addr, 32'h500);
    reg_write(c_a_len, 32'd4);
    reg_write(c_a_pattern, 32'h11);
    push_exp(32'h500, 1, 32'h11, 1'b0, 1'b1);
    reg_write(c_a_ctrl, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (obi_req.req !== 1'b0 || done_int !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_out: req=%b done=%b, required 0 0", obi_req.req, done_int);
    end
    @(negedge clk);
    reg_read(c_a_status, v, err);
    n_total++;
    if (v !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid_status: got %h, required 0", v);
    end
    bad_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done_int !== 1'b0 || obi_req.req !== 1'b0) bad_seen = 1'b1;
    end
    n_total++;
    if (bad_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_hold: activity during reset, required none");
    end
    rst_n = 1'b1;
    exp_q.delete();
    rd_q.delete();
    rv_dly = 0;
    @(negedge clk);
    reg_read(c_a_addr, v, err);
    n_total++;
    if (v !== 32'h0) begin
      n_bad++;
      $display("FAIL rst_mid_addr: got %h, required 0", v);
    end
    reg_write(c_a_addr, 32'h600);
    reg_write(c_a_len, 32'd2);
    reg_write(c_a_pattern, 32'h33);
    push_exp(32'h600, 2, 32'h33, 1'b1, 1'b1);
    reg_write(c_a_ctrl, 32'h5);
    wait_done(100, cyc);
    n_total++;
    if (cyc < 0) begin
      n_bad++;
      $display("FAIL post_rst_done: no done pulse, required one");
    end
    @(negedge clk);
    reg_read(c_a_count, v, err);
    n_total++;
    if (v !== 32'd2) begin
      n_bad++;
      $display("FAIL post_rst_count: got %0d, required 2", v);
    end
    n_total++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL post_rst_pending: %0d expected requests left, required 0", exp_q.size());
    end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    reg_req = '0;
    fork
      slave_loop();
    join_none
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_fill();
    test_read_sum();
    test_backpressure();
    test_abort();
    test_len0();
    test_wrap();
    test_bad_offset();
    test_reset_midjob();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
